fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the team's asynchronous FIFO, sitting directly downstream of `bin2gray` in the write clock domain. It takes the Gray-coded write pointer from `bin2gray` and synchronises it into the read clock domain with two flops. It converts that pointer back to binary, maintains the read pointer, and produces the empty flag, RAM read address, read-valid strobe and occupancy level. It also exports its own registered Gray read pointer for the write side's full logic.

## Interface
Parameters:
- `WIDTH`, 8, pointer width in bits; RAM depth is 2^(WIDTH-1), and the MSB is the wrap bit.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` input 1: read-domain clock; all state changes on its rising edge.
- `sys_rst` input 1: synchronous, active-high reset.
- `wr_ptr_gray` input WIDTH: Gray write pointer from `bin2gray`; asynchronous to `sys_clk`.
- `rd_en` input 1: read request.
- `rd_addr` output WIDTH-1: RAM read address, equal to `rd_ptr_bin[WIDTH-2:0]`, driven from a register.
- `rd_valid` output 1: RAM data valid, one cycle after an accepted read.
- `empty` output 1: FIFO empty; registered.
- `rd_ptr_gray` output WIDTH: registered Gray read pointer, sent to the write domain.
- `rd_level` output WIDTH: registered occupancy, `wr_bin_sync − rd_ptr_bin` mod 2^WIDTH.

## Operation
- Sync chain: `wr_sync1 <= wr_ptr_gray`, then `wr_sync2 <= wr_sync1`. No logic between the two flops.
- `wr_bin_sync` = gray2bin(`wr_sync2`), combinational.
- Accept condition: `accept = rd_en & ~empty`. When `empty` = 1, `rd_en` is ignored: no pointer change and `rd_valid` stays 0.
- On accept:
  - `rd_ptr_bin` increments mod 2^WIDTH.
  - `rd_ptr_gray <= next_bin ^ (next_bin >> 1)`.
- `rd_addr` presented during the accept cycle is the entry being read.
- `rd_valid <= accept`; this matches a 1-cycle registered-read RAM.
- `empty <= (rd_gray_next == wr_sync2)`:
  - `rd_gray_next` is the Gray code of the post-accept pointer.
  - The flag therefore asserts on the same edge that consumes the last entry. No extra read can slip through.
- `rd_level <= wr_bin_sync − rd_bin_next`, WIDTH-bit unsigned wrap subtraction. Maximum legal value is 2^(WIDTH-1). No saturation.
- Wrap-around: the pointer rolls from 2^WIDTH−1 to 0. With WIDTH=8, Gray 0x80 goes to 0x00. No special case.
- Upstream contract: `wr_ptr_gray` changes at most one bit per write-clock edge. Multi-bit changes are not detected.
- Reset, including mid-operation: on the next edge, all of the following clear to 0:
  - `wr_sync1`, `wr_sync2`
  - `rd_ptr_bin`, `rd_ptr_gray`
  - `rd_valid`, `rd_level`

  `empty` is set to 1. An in-flight `rd_valid` is dropped.

## Timing
- Write-pointer change to `empty`/`rd_level` update:
  - `wr_ptr_gray` changes before edge E0.
  - `wr_sync1` captures it at E0 and `wr_sync2` at E1.
  - `empty` and `rd_level` update at E2, i.e. 3 edges after the change.
- `rd_en` to `rd_valid`: 1 cycle. Back-to-back accepts are allowed every cycle.
- `rd_ptr_gray` is updated on the accept edge and is glitch-free, being a direct flop output.
- All outputs are registered. There is no combinational path from `rd_en` or `wr_ptr_gray` to any output.

## Structure
- Shared `fifo_defs.vh`: default `WIDTH`, the `RD_LATENCY`=1 constant, and the reset value of `empty`. The write-side controller uses the same file.
- Sub-module `gray2bin` (parameter `WIDTH`, combinational XOR prefix), the inverse of `bin2gray`. It is instantiated once on `wr_sync2`.
- A single always block per register group: sync chain, read pointer, and flags/level.

## Test plan
1. Reset: hold `sys_rst`=1 for 2 cycles. Required: `empty`=1, `rd_ptr_gray`=0x00, `rd_addr`=0x00, `rd_valid`=0, `rd_level`=0.
2. Single write and read:
   - Drive `wr_ptr_gray` 0x00→0x01 before E0. Required: `empty`=0 and `rd_level`=1 after E2.
   - Then `rd_en`=1 for one cycle. Required: `rd_addr`=0x00 during the accept; `rd_ptr_gray`=0x01 and `empty`=1 after the edge; `rd_valid`=1 for exactly one following cycle.
3. Read while empty: `rd_en`=1 for 5 cycles with `empty`=1. Required: pointers unchanged and `rd_valid`=0 throughout.
4. Burst: `rd_level`=3 with `wr_ptr_gray`=0x02 (binary 3). Apply `rd_en`=1 for 4 cycles. Required:
   - `rd_addr` 0,1,2 on the three accepts; the 4th request is ignored.
   - `rd_valid` high for 3 cycles.
   - `empty`=1 on the third accept edge.
5. Wrap and full depth, using a Gray-stepped write pointer throughout:
   - Step the write pointer to binary 128 (Gray 0xC0). Required: `rd_level`=128.
   - Read 128 entries. Required: `rd_ptr_gray`=0xC0, `rd_addr` wraps back to 0x00, `empty`=1.
   - Advance the write pointer to binary 255, then binary 0, then 1, and read after each step. Required: the pointer passes 255→0 cleanly.
6. Reset mid-burst: assert `sys_rst` during a `rd_en` burst with level 4. Required: all outputs at reset values on the next edge, `rd_valid`=0, and no accept on that edge.

Source files
------------

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants for the asynchronous FIFO read/write controllers.
package fifo_rd_ctrl_pkg;

  // Default pointer width: MSB is the wrap bit, RAM depth is 2^(width-1)
  localparam int unsigned FIFO_PTR_WIDTH = 8;

  // Cycles from an accepted read to valid RAM data
  localparam int unsigned RD_LATENCY = 1;

  // Value the empty flag takes while in reset
  localparam logic EMPTY_RST_VAL = 1'b1;

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at
// or above it. Pure combinational, inverse of the write-side bin2gray.
module fifo_rd_ctrl_gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB downwards
  always_comb begin
    bin = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO. Synchronises the Gray write
// pointer into the read domain, owns the read pointer and produces empty,
// read address, read-valid strobe and occupancy, all from registers.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int WIDTH = FIFO_PTR_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] wr_ptr_gray,
  input  logic             rd_en,
  output logic [WIDTH-2:0] rd_addr,
  output logic             rd_valid,
  output logic             empty,
  output logic [WIDTH-1:0] rd_ptr_gray,
  output logic [WIDTH-1:0] rd_level
);

  logic [WIDTH-1:0] wr_sync1_r;
  logic [WIDTH-1:0] wr_sync2_r;
  logic [WIDTH-1:0] wr_bin_sync_s;
  logic [WIDTH-1:0] rd_ptr_bin_r;
  logic [WIDTH-1:0] rd_ptr_gray_r;
  logic [WIDTH-1:0] rd_bin_next_s;
  logic [WIDTH-1:0] rd_gray_next_s;
  logic [WIDTH-1:0] rd_level_r;
  logic             accept_s;
  logic             rd_valid_r;
  logic             empty_r;

  function automatic logic [WIDTH-1:0] bin2gray_f(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Write pointer back to binary for the occupancy subtraction
  fifo_rd_ctrl_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (wr_sync2_r),
    .bin  (wr_bin_sync_s)
  );

  // Read acceptance and the post-accept pointer in both encodings
  always_comb begin
    accept_s      = 1'b0;
    rd_bin_next_s = rd_ptr_bin_r;
    accept_s      = rd_en & ~empty_r;
    if (accept_s) begin
      rd_bin_next_s = rd_ptr_bin_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rd_bin_next_s = rd_ptr_bin_r;
    end
    rd_gray_next_s = bin2gray_f(rd_bin_next_s);
  end

  // Two-flop synchroniser for the Gray write pointer, no logic in between
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_sync1_r <= {WIDTH{1'b0}};
      wr_sync2_r <= {WIDTH{1'b0}};
    end else begin
      wr_sync1_r <= wr_ptr_gray;
      wr_sync2_r <= wr_sync1_r;
    end
  end

  // Read pointer, kept in binary for addressing and in Gray for the write side
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr_bin_r  <= {WIDTH{1'b0}};
      rd_ptr_gray_r <= {WIDTH{1'b0}};
    end else begin
      rd_ptr_bin_r  <= rd_bin_next_s;
      rd_ptr_gray_r <= rd_gray_next_s;
    end
  end

  // Flags and level judged on the post-accept pointer so the last read
  // raises empty on its own edge and no extra read can slip through
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_valid_r <= 1'b0;
      empty_r    <= EMPTY_RST_VAL;
      rd_level_r <= {WIDTH{1'b0}};
    end else begin
      rd_valid_r <= accept_s;
      empty_r    <= (rd_gray_next_s == wr_sync2_r);
      rd_level_r <= wr_bin_sync_s - rd_bin_next_s;
    end
  end

  assign rd_addr     = rd_ptr_bin_r[WIDTH-2:0];
  assign rd_valid    = rd_valid_r;
  assign empty       = empty_r;
  assign rd_ptr_gray = rd_ptr_gray_r;
  assign rd_level    = rd_level_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed test-plan scenarios followed
// by randomized traffic, all compared against a behavioural FIFO model.
module tb_fifo_rd_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] wr_ptr_gray;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic       rd_valid;
  logic       empty;
  logic [7:0] rd_ptr_gray;
  logic [7:0] rd_level;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: count of writes and reads, with the write count seen
  // by the read side lagging two read-clock samples behind.
  int wr_bin;
  int m_rd;
  int m_empty;
  int m_valid;
  int m_level;
  int seen_d1;
  int seen_d2;

  fifo_rd_ctrl #(.WIDTH(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_level    (rd_level)
  );

  // Read-domain clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  task automatic set_wr(input int b);
    wr_bin      = b & 255;
    wr_ptr_gray = 8'(gray_of(wr_bin));
  endtask

  // Advance the model by one rising edge using the inputs held across it
  task automatic model_step();
    int vis;
    int acc;
    vis = seen_d2;
    if (sys_rst) begin
      seen_d2 = 0;
      seen_d1 = 0;
      m_rd    = 0;
      m_empty = 1;
      m_valid = 0;
      m_level = 0;
    end else begin
      seen_d2 = seen_d1;
      seen_d1 = wr_bin;
      acc     = (rd_en && !m_empty) ? 1 : 0;
      if (acc != 0) m_rd = (m_rd + 1) & 255;
      m_valid = acc;
      m_empty = (m_rd == vis) ? 1 : 0;
      m_level = (vis - m_rd) & 255;
    end
  endtask

  task automatic check_all();
    check_val("empty",    32'(empty),       32'(m_empty));
    check_val("rd_valid", 32'(rd_valid),    32'(m_valid));
    check_val("rd_level", 32'(rd_level),    32'(m_level));
    check_val("rd_gray",  32'(rd_ptr_gray), 32'(gray_of(m_rd)));
    check_val("rd_addr",  32'(rd_addr),     32'(m_rd % 128));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Step the write pointer one count per cycle up to a target (mod 256)
  task automatic walk_wr_to(input int target);
    while (wr_bin != (target & 255)) begin
      set_wr(wr_bin + 1);
      tick();
    end
  endtask

  // Keep reading until the model reports empty, bounded
  task automatic drain();
    int guard = 0;
    rd_en = 1'b1;
    while (m_empty == 0 && guard < 300) begin
      tick();
      guard++;
    end
    rd_en = 1'b0;
    check_val("drain_bound", 32'(m_empty), 32'd1);
  endtask

  initial begin
    int vcnt;
    sys_rst = 1'b1;
    rd_en   = 1'b0;
    m_rd = 0; m_empty = 1; m_valid = 0; m_level = 0; seen_d1 = 0; seen_d2 = 0;
    set_wr(0);

    // 1. Reset
    ticks(2);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_gray",  32'(rd_ptr_gray), 32'd0);
    check_val("rst_addr",  32'(rd_addr), 32'd0);
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_level", 32'(rd_level), 32'd0);
    sys_rst = 1'b0;
    tick();

    // 2. Single write and read: update lands on the third edge
    set_wr(1);
    ticks(2);
    check_val("lat_empty_e1", 32'(empty), 32'd1);
    tick();
    check_val("one_empty", 32'(empty), 32'd0);
    check_val("one_level", 32'(rd_level), 32'd1);
    rd_en = 1'b1;
    check_val("one_addr", 32'(rd_addr), 32'd0);
    tick();
    rd_en = 1'b0;
    check_val("one_gray",  32'(rd_ptr_gray), 32'h01);
    check_val("one_empty_after", 32'(empty), 32'd1);
    check_val("one_valid", 32'(rd_valid), 32'd1);
    tick();
    check_val("one_valid_drop", 32'(rd_valid), 32'd0);

    // 3. Read while empty
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("emptyrd_valid", 32'(rd_valid), 32'd0);
      check_val("emptyrd_gray",  32'(rd_ptr_gray), 32'h01);
    end
    rd_en = 1'b0;

    // 4. Burst of three with a fourth request ignored
    walk_wr_to(3);
    ticks(3);
    check_val("burst_level", 32'(rd_level), 32'd2);
    set_wr(4);
    ticks(3);
    check_val("burst_level3", 32'(rd_level), 32'd3);
    rd_en = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_valid) vcnt++;
      if (i == 2) check_val("burst_empty_3rd", 32'(empty), 32'd1);
    end
    rd_en = 1'b0;
    tick();
    check_val("burst_valid_cnt", 32'(vcnt), 32'd3);
    check_val("burst_addr_end", 32'(rd_addr), 32'd4);

    // 5. Full depth and wrap: level 128 relative to read pointer 4
    walk_wr_to(132);
    ticks(3);
    check_val("full_level", 32'(rd_level), 32'd128);
    drain();
    check_val("full_gray",  32'(rd_ptr_gray), 32'(gray_of(132)));
    check_val("full_addr",  32'(rd_addr), 32'd4);
    walk_wr_to(255); ticks(3); drain();
    walk_wr_to(0);   ticks(3); drain();
    check_val("wrap_gray0", 32'(rd_ptr_gray), 32'h00);
    walk_wr_to(1);   ticks(3); drain();
    check_val("wrap_gray1", 32'(rd_ptr_gray), 32'h01);

    // 5b. Exact plan case from a fresh reset: write pointer at binary 128
    sys_rst = 1'b1;
    set_wr(0);
    ticks(2);
    sys_rst = 1'b0;
    walk_wr_to(128);
    ticks(3);
    check_val("plan_level128", 32'(rd_level), 32'd128);
    drain();
    check_val("plan_gray_c0", 32'(rd_ptr_gray), 32'hC0);
    check_val("plan_addr0",   32'(rd_addr), 32'h00);
    check_val("plan_empty",   32'(empty), 32'd1);

    // 6. Reset in the middle of a burst at level 4
    walk_wr_to(132);
    ticks(3);
    check_val("mid_level", 32'(rd_level), 32'd4);
    rd_en = 1'b1;
    tick();
    sys_rst = 1'b1;
    tick();
    check_val("mid_valid", 32'(rd_valid), 32'd0);
    check_val("mid_empty", 32'(empty), 32'd1);
    check_val("mid_gray",  32'(rd_ptr_gray), 32'd0);
    sys_rst = 1'b0;
    rd_en   = 1'b0;
    set_wr(0);
    sys_rst = 1'b1;
    ticks(2);
    sys_rst = 1'b0;

    // Randomized traffic with an occasional reset
    for (int c = 0; c < 3000; c++) begin
      rd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && ((wr_bin - m_rd) & 255) < 127)
        set_wr(wr_bin + 1);
      if ($urandom_range(0, 299) == 0) begin
        sys_rst = 1'b1;
        set_wr(0);
      end else begin
        sys_rst = 1'b0;
      end
      tick();
    end
    sys_rst = 1'b0;
    rd_en   = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
